seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for N_DIGITS common-cathode/anode 7-segment digits sharing one segment bus.
//  Decodes 5-bit per-digit codes (hex glyphs, blank, bar) and scans the digits one at a time.
//  Adds decimal points, leading-zero blanking, 16-level PWM brightness and tear-free frame-synchronous update.
//  Sits between the clock/counter datapath and the board's segment/digit pins.
// PARAMETERS
//  N_DIGITS     4      number of digits scanned (>=2)
//  SCAN_DIV     50000  clk cycles per digit slot (multiple of 16, >=16)
//  SEG_ACT_LOW  0      1 = invert seg outputs at the port
//  DIG_ACT_LOW  0      1 = invert dig outputs at the port
// PORTS
//  clk      in   1           system clock, all logic on rising edge
//  rst      in   1           asynchronous reset, active-high
//  load     in   1           1-cycle strobe: capture data_in/dp_in into the shadow register
//  data_in  in   5*N_DIGITS  code of digit i at [5i+4:5i]; digit 0 = least significant (rightmost)
//  dp_in    in   N_DIGITS    decimal point of digit i
//  bri      in   4           brightness 0..15
//  lzb_en   in   1           leading-zero blanking enable
//  seg      out  8           {dp,g,f,e,d,c,b,a}, registered
//  dig      out  N_DIGITS    one-hot digit enable, registered
//  frame    out  1           1-cycle pulse, registered, at the start of each digit-0 slot
//  pending  out  1           shadow holds data not yet shown
// BEHAVIOUR
//  Reset: div_cnt=0, idx=0, shadow and display codes = 0x10 (blank), dp=0, pending=0;
//   seg and dig driven "off" at port polarity (0x00 / all 0 when ACT_LOW=0), frame=0.
//  Scan: div_cnt counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and idx increments, N_DIGITS-1 -> 0.
//  Sub-phase sp = div_cnt / (SCAN_DIV/16), range 0..15. Digit idx is lit iff sp <= bri:
//   bri=15 always lit, bri=0 lit 1/16 of slot. When unlit, dig = 0 and seg = 0x00 (pre-polarity).
//  Outputs are registered from the current (idx, div_cnt): one cycle latency.
//   frame=1 in the cycle after div_cnt==0 && idx==0 is evaluated.
//  Decode (active-high): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71;
//   code 0x10 = blank 0x00; codes 0x11..0x1F = bar 0x40. seg[7] = dp of the digit, also on blank/bar.
//  Leading-zero blanking (lzb_en=1): scanning from digit N_DIGITS-1 down, a digit with code 0 and dp=0
//   is shown blank until the first digit with nonzero code or dp=1; digit 0 is never blanked.
//   Evaluated combinationally on the display register, so it tracks lzb_en without a reload.
//  Update handshake: load=1 -> shadow <= {data_in,dp_in}, pending <= 1 next cycle.
//   Frame boundary (div_cnt==SCAN_DIV-1 && idx==N_DIGITS-1): if pending, display <= shadow, pending <= 0.
//   load coincident with boundary: display <= data_in/dp_in directly, shadow updated too, pending <= 0.
//   Repeated loads before boundary: last one wins; no data is ever shown partially within a frame.
//  bri and lzb_en are not synchronised to frames; changes take effect the next cycle.
//  Reset mid-frame: everything returns to reset values immediately (async); scan restarts at digit 0.
//  Port polarity: seg = SEG_ACT_LOW ? ~s : s; dig likewise with DIG_ACT_LOW; applied inside the output register.
// TESTING (N_DIGITS=4, SCAN_DIV=16, polarities 0, bri=15, lzb_en=0 unless stated)
//  1 Assert rst mid-run -> seg=00, dig=0000, frame=0, pending=0 same cycle; after release first lit dig=0001, seg=00.
//  2 load codes {d3..d0}={4,3,2,1} mid-frame -> pending=1 until boundary; next frame dig 0001/0010/0100/1000
//    show seg 06/5B/4F/66, 16 cycles each; frame pulses every 64 cycles.
//  3 bri=3 -> each digit lit exactly 4 of 16 cycles (div_cnt 0..3); bri=0 -> 1 cycle; dig=0000 otherwise.
//  4 lzb_en=1, codes {0,0,7,0} -> digits 3,2 blank (00), digit1 07, digit0 3F; set dp_in[3]=1 -> digit3 shows 0xBF, digit2 3F.
//  5 codes {0x15,0x10,0x0E,0x0B}, dp_in=0001 -> seg 0xFC, 79, 00, 40 for digits 0..3.
//  6 load pulse exactly on frame boundary with codes {9,9,9,9} -> next frame shows 6F on all digits, pending stays 0;
//    two loads in one frame -> only the second is displayed.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner with PWM brightness, leading-zero
// blanking and frame-synchronous double-buffered display update.
module seg7_scan_driver #(
    parameter int N_DIGITS    = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int SEG_ACT_LOW = 0,
    parameter int DIG_ACT_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [5*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [3:0]            bri,
    input  logic                  lzb_en,
    output logic [7:0]            seg,
    output logic [N_DIGITS-1:0]   dig,
    output logic                  frame,
    output logic                  pending
);

    localparam int CW  = $clog2(SCAN_DIV);
    localparam int IW  = $clog2(N_DIGITS);
    localparam int SUB = SCAN_DIV / 16;

    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [7:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] DIG_OFF =
        (DIG_ACT_LOW != 0) ? '1 : '0;
    localparam logic [5*N_DIGITS-1:0] BLANK_ALL = {N_DIGITS{5'h10}};

    logic [CW-1:0]         div_cnt;
    logic [IW-1:0]         idx;
    logic [5*N_DIGITS-1:0] shadow_code;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [5*N_DIGITS-1:0] disp_code;
    logic [N_DIGITS-1:0]   disp_dp;

    logic                  boundary;
    logic                  lit;
    logic [4:0]            cur_code;
    logic                  cur_dp;
    logic [N_DIGITS-1:0]   blank;
    logic                  lead;
    logic [7:0]            s;
    logic [N_DIGITS-1:0]   d;

    function automatic logic [6:0] glyph(input logic [4:0] c);
        logic [6:0] g;
        case (c)
            5'h00: g = 7'h3F;
            5'h01: g = 7'h06;
            5'h02: g = 7'h5B;
            5'h03: g = 7'h4F;
            5'h04: g = 7'h66;
            5'h05: g = 7'h6D;
            5'h06: g = 7'h7D;
            5'h07: g = 7'h07;
            5'h08: g = 7'h7F;
            5'h09: g = 7'h6F;
            5'h0A: g = 7'h77;
            5'h0B: g = 7'h7C;
            5'h0C: g = 7'h39;
            5'h0D: g = 7'h5E;
            5'h0E: g = 7'h79;
            5'h0F: g = 7'h71;
            5'h10: g = 7'h00;
            default: g = 7'h40;
        endcase
        return g;
    endfunction

    assign boundary = (div_cnt == DIV_LAST) && (idx == IDX_LAST);
    assign lit      = (div_cnt / CW'(SUB)) <= CW'(bri);
    assign cur_code = disp_code[idx*5 +: 5];
    assign cur_dp   = disp_dp[idx];

    // Walk from the most significant digit; the first nonzero
    // code or set dp ends the run of blanked zeros.
    always_comb begin
        blank = '0;
        lead  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (lead && disp_code[i*5 +: 5] == 5'd0 && !disp_dp[i])
                blank[i] = 1'b1;
            else
                lead = 1'b0;
        end
    end

    always_comb begin
        s = 8'h00;
        d = '0;
        if (lit) begin
            s = {cur_dp, (lzb_en && blank[idx]) ? 7'h00 : glyph(cur_code)};
            d = N_DIGITS'(1) << idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_code <= BLANK_ALL;
            shadow_dp   <= '0;
            disp_code   <= BLANK_ALL;
            disp_dp     <= '0;
            pending     <= 1'b0;
        end else if (load) begin
            shadow_code <= data_in;
            shadow_dp   <= dp_in;
            if (boundary) begin
                disp_code <= data_in;
                disp_dp   <= dp_in;
                pending   <= 1'b0;
            end else begin
                pending   <= 1'b1;
            end
        end else if (boundary && pending) begin
            disp_code <= shadow_code;
            disp_dp   <= shadow_dp;
            pending   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg   <= SEG_OFF;
            dig   <= DIG_OFF;
            frame <= 1'b0;
        end else begin
            seg   <= s ^ SEG_OFF;
            dig   <= d ^ DIG_OFF;
            frame <= (div_cnt == '0) && (idx == '0);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: vector table checked frame
// by frame, plus reset, boundary-load and live-control sequences.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [19:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  bri = 4'd15;
    logic        lzb_en = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic        frame;
    logic        pending;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(
        .N_DIGITS(4),
        .SCAN_DIV(16),
        .SEG_ACT_LOW(0),
        .DIG_ACT_LOW(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .data_in(data_in),
        .dp_in(dp_in),
        .bri(bri),
        .lzb_en(lzb_en),
        .seg(seg),
        .dig(dig),
        .frame(frame),
        .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] codes;
        logic [3:0]  dp;
        logic [3:0]  bri;
        logic        lzb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (!frame && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("frame_timeout", {31'd0, frame}, 32'd1);
    endtask

    task automatic pulse_load(input logic [19:0] c, input logic [3:0] p);
        data_in = c;
        dp_in   = p;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic do_load(input logic [19:0] c, input logic [3:0] p);
        wait_frame();
        repeat (5) @(negedge clk);
        pulse_load(c, p);
        chk("pending_set", {31'd0, pending}, 32'd1);
    endtask

    task automatic wait_shown();
        int n;
        n = 0;
        while (pending && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("pending_clear", {31'd0, pending}, 32'd0);
        wait_frame();
    endtask

    // Entered on the sample where frame=1 (digit 0, sub-phase 0).
    task automatic check_frame(input logic [31:0] exp, input logic [3:0] b);
        logic [7:0] es;
        logic [3:0] ed;
        int dg;
        chk("frame_start", {31'd0, frame}, 32'd1);
        for (int k = 0; k < 64; k++) begin
            dg = k / 16;
            if ((k % 16) <= int'(b)) begin
                es = exp[dg*8 +: 8];
                ed = 4'b0001 << dg;
            end else begin
                es = 8'h00;
                ed = 4'b0000;
            end
            chk($sformatf("seg k=%0d", k), {24'd0, seg}, {24'd0, es});
            chk($sformatf("dig k=%0d", k), {28'd0, dig}, {28'd0, ed});
            @(negedge clk);
        end
    endtask

    initial begin
        int n;

        vecs[0] = '{{5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 4'd15, 1'b0,
                    {8'h66, 8'h4F, 8'h5B, 8'h06}};
        vecs[1] = '{{5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 4'd3, 1'b0,
                    {8'h66, 8'h4F, 8'h5B, 8'h06}};
        vecs[2] = '{{5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 4'd0, 1'b0,
                    {8'h66, 8'h4F, 8'h5B, 8'h06}};
        vecs[3] = '{{5'd0, 5'd0, 5'd7, 5'd0}, 4'b0000, 4'd15, 1'b1,
                    {8'h00, 8'h00, 8'h07, 8'h3F}};
        vecs[4] = '{{5'd0, 5'd0, 5'd7, 5'd0}, 4'b1000, 4'd15, 1'b1,
                    {8'hBF, 8'h3F, 8'h07, 8'h3F}};
        vecs[5] = '{{5'h15, 5'h10, 5'h0E, 5'h0B}, 4'b0001, 4'd15, 1'b0,
                    {8'h40, 8'h00, 8'h79, 8'hFC}};
        vecs[6] = '{{5'hF, 5'hA, 5'h8, 5'h5}, 4'b0000, 4'd9, 1'b0,
                    {8'h71, 8'h77, 8'h7F, 8'h6D}};
        vecs[7] = '{{5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 4'd15, 1'b1,
                    {8'h00, 8'h00, 8'h00, 8'h3F}};
        vecs[8] = '{{5'hC, 5'hD, 5'h6, 5'h0}, 4'b0000, 4'd7, 1'b1,
                    {8'h39, 8'h5E, 8'h7D, 8'h3F}};
        vecs[9] = '{{5'h0, 5'h1F, 5'h0, 5'h0}, 4'b0000, 4'd15, 1'b1,
                    {8'h00, 8'h40, 8'h3F, 8'h3F}};

        repeat (3) @(negedge clk);
        chk("rst_seg", {24'd0, seg}, 32'h00);
        chk("rst_dig", {28'd0, dig}, 32'h0);
        chk("rst_frame", {31'd0, frame}, 32'd0);
        chk("rst_pending", {31'd0, pending}, 32'd0);
        rst = 1'b0;

        wait_frame();
        check_frame(32'h0, 4'd15);

        for (int v = 0; v < 10; v++) begin
            bri    = vecs[v].bri;
            lzb_en = vecs[v].lzb;
            do_load(vecs[v].codes, vecs[v].dp);
            wait_shown();
            check_frame(vecs[v].exp, vecs[v].bri);
        end

        bri    = 4'd15;
        lzb_en = 1'b1;
        do_load({5'd0, 5'd0, 5'd7, 5'd0}, 4'b0000);
        wait_shown();
        check_frame({8'h00, 8'h00, 8'h07, 8'h3F}, 4'd15);
        lzb_en = 1'b0;
        wait_frame();
        check_frame({8'h3F, 8'h3F, 8'h07, 8'h3F}, 4'd15);

        wait_frame();
        repeat (3) @(negedge clk);
        pulse_load({4{5'd1}}, 4'b0000);
        repeat (10) @(negedge clk);
        pulse_load({4{5'd2}}, 4'b0000);
        wait_shown();
        check_frame({4{8'h5B}}, 4'd15);

        wait_frame();
        repeat (62) @(negedge clk);
        pulse_load({4{5'd9}}, 4'b0000);
        chk("bnd_pending", {31'd0, pending}, 32'd0);
        @(negedge clk);
        check_frame({4{8'h6F}}, 4'd15);
        chk("bnd_pending_after", {31'd0, pending}, 32'd0);

        wait_frame();
        n = 0;
        @(negedge clk);
        while (!frame && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("frame_period", n + 1, 32'd64);

        do_load({4{5'd5}}, 4'b0000);
        rst = 1'b1;
        #1;
        chk("async_seg", {24'd0, seg}, 32'h00);
        chk("async_dig", {28'd0, dig}, 32'h0);
        chk("async_frame", {31'd0, frame}, 32'd0);
        chk("async_pending", {31'd0, pending}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        @(negedge clk);
        while (dig == 4'd0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("post_rst_dig", {28'd0, dig}, 32'h1);
        chk("post_rst_seg", {24'd0, seg}, 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
